// File: rtl/line_buffer_window_sched.sv
// Read-side scheduler for a 4-slot line buffer: issues 3-row window reads for a 3x3 kernel and
// releases slots back to the writer. Macro WINDOW_BORDER_EN adds edge-replicated first/last rows.
module line_buffer_window_sched #(
  parameter int LINE_W    = 512,
  parameter int NUM_LINES = 512,
  parameter int ADDR_W    = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-3:0] line_counter,
  input  logic              out_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic              pix_valid,
  output logic [ADDR_W-3:0] row_o,
  output logic [ADDR_W-3:0] col_o,
  output logic              interrupt,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW  = ADDR_W - 2;
  localparam int LAW = CW + 1;
  localparam logic [CW-1:0]  COL_LAST  = CW'(LINE_W - 1);
  localparam logic [LAW-1:0] LINES_MAX = LAW'(NUM_LINES);
  localparam logic [CW-1:0]  INT_LAST  = CW'(NUM_LINES - 4);
`ifdef WINDOW_BORDER_EN
  localparam logic [CW-1:0]  ROW_FIRST = '0;
  localparam logic [CW-1:0]  ROW_LAST  = CW'(NUM_LINES - 1);
`else
  localparam logic [CW-1:0]  ROW_FIRST = CW'(1);
  localparam logic [CW-1:0]  ROW_LAST  = CW'(NUM_LINES - 2);
`endif

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_LINE_END, S_FLUSH} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  r_q, r_d;
  logic [CW-1:0]  col_q, col_d;
  logic [CW-1:0]  lc_q;
  logic [LAW-1:0] avail_q, avail_d;
  logic           pv_q;
  logic [CW-1:0]  row_q, colo_q;
  logic           line_chg;
  logic [LAW-1:0] need;
  logic [CW-1:0]  line_m1, line_p1;

  assign line_chg = line_counter != lc_q;

  // Row r needs lines 0..r+1 written; the last border row needs no line beyond the frame.
  always_comb begin
    need = {1'b0, r_q} + LAW'(2);
    if (need > LINES_MAX) need = LINES_MAX;
  end

`ifdef WINDOW_BORDER_EN
  assign line_m1 = (r_q == '0) ? r_q : r_q - 1'b1;
  assign line_p1 = (r_q == ROW_LAST) ? r_q : r_q + 1'b1;
`else
  assign line_m1 = r_q - 1'b1;
  assign line_p1 = r_q + 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    col_d      = col_q;
    rd_en      = 1'b0;
    interrupt  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          r_d     = ROW_FIRST;
          col_d   = '0;
        end
      end
      S_WAIT: begin
        if (avail_q >= need) begin
          state_d = S_SCAN;
          col_d   = '0;
        end
      end
      S_SCAN: begin
        if (out_ready) begin
          rd_en = 1'b1;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = S_LINE_END;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_LINE_END: begin
        // Line r-1 is no longer referenced by any later window once r is done.
        interrupt = (r_q != '0) && (r_q <= INT_LAST);
        if (r_q == ROW_LAST) begin
          state_d = S_FLUSH;
        end else begin
          r_d     = r_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_FLUSH: begin
        if (!pv_q) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lines counted while idle stay valid so a frame can be armed after the writer preloads;
  // the count restarts once a frame has fully drained.
  always_comb begin
    avail_d = avail_q;
    if (line_chg && (avail_q != LINES_MAX)) avail_d = avail_q + 1'b1;
    if (frame_done) avail_d = {{CW{1'b0}}, line_chg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= CW'(1);
      col_q   <= '0;
      lc_q    <= '0;
      avail_q <= '0;
      pv_q    <= 1'b0;
      row_q   <= '0;
      colo_q  <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      col_q   <= col_d;
      lc_q    <= line_counter;
      avail_q <= avail_d;
      pv_q    <= rd_en;
      row_q   <= rd_en ? r_q : '0;
      colo_q  <= rd_en ? col_q : '0;
    end
  end

  assign rd_addr0  = rd_en ? {line_m1[1:0], col_q} : '0;
  assign rd_addr1  = rd_en ? {r_q[1:0], col_q} : '0;
  assign rd_addr2  = rd_en ? {line_p1[1:0], col_q} : '0;
  assign pix_valid = pv_q;
  assign row_o     = row_q;
  assign col_o     = colo_q;
  assign busy      = (state_q != S_IDLE) && !frame_done;

endmodule

// File: tb/tb_line_buffer_window_sched.sv
// Bench for line_buffer_window_sched: random-stall frames checked against a row/column window
// sequence model with a writer that refills one line per interrupt.
`timescale 1ns/1ps
module tb_line_buffer_window_sched;
  localparam int LW = 512;
  localparam int NL = 16;
`ifdef WINDOW_BORDER_EN
  localparam int FIRST = 0;
  localparam int LAST  = NL - 1;
  localparam logic [32:0] FIRST_ADDRS = {11'h000, 11'h000, 11'h200};
  localparam logic EXP_INT1 = 1'b0;
`else
  localparam int FIRST = 1;
  localparam int LAST  = NL - 2;
  localparam logic [32:0] FIRST_ADDRS = {11'h000, 11'h200, 11'h400};
  localparam logic EXP_INT1 = 1'b1;
`endif
  localparam int ROWS = LAST - FIRST + 1;

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [8:0]  line_counter;
  logic        rd_en, pix_valid, interrupt, busy, frame_done;
  logic [10:0] rd_addr0, rd_addr1, rd_addr2;
  logic [8:0]  row_o, col_o;

  int n_cmp = 0, n_bad = 0;

  int iss_r = 0, iss_c = 0, pv_r = 0, pv_c = 0, avail = 0;
  logic [8:0] lc_prev = 9'd0;
  int n_pix = 0, n_int = 0, n_done = 0;
  int seq_bad = 0, addr_bad = 0, early_bad = 0, ready_bad = 0;
  int pix_per_row [NL];
  logic [32:0] first_addrs [NL];

  always #5 clk = ~clk;

  line_buffer_window_sched #(.LINE_W(LW), .NUM_LINES(NL), .ADDR_W(11)) dut (
    .clk(clk), .reset(reset), .start(start), .line_counter(line_counter),
    .out_ready(out_ready), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .pix_valid(pix_valid), .row_o(row_o), .col_o(col_o),
    .interrupt(interrupt), .busy(busy), .frame_done(frame_done)
  );

  // Window line index is clamped to the frame (edge replication), slot = line mod 4.
  function automatic logic [10:0] exp_addr(input int line, input int col);
    int l;
    l = (line < 0) ? 0 : ((line > NL - 1) ? NL - 1 : line);
    return 11'((l % 4) * 512 + col);
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      iss_r = FIRST; iss_c = 0; pv_r = FIRST; pv_c = 0; avail = 0; lc_prev = 9'd0;
    end else begin
      if (start && !busy) begin
        iss_r = FIRST; iss_c = 0; pv_r = FIRST; pv_c = 0;
        for (int i = 0; i < NL; i++) begin pix_per_row[i] = 0; first_addrs[i] = '0; end
      end
      if (line_counter != lc_prev) begin
        lc_prev = line_counter;
        if (avail < NL) avail++;
      end
      if (rd_en) begin
        if (!out_ready) ready_bad++;
        if (avail < ((iss_r + 2 > NL) ? NL : iss_r + 2)) early_bad++;
        if (rd_addr0 !== exp_addr(iss_r - 1, iss_c) || rd_addr1 !== exp_addr(iss_r, iss_c) ||
            rd_addr2 !== exp_addr(iss_r + 1, iss_c)) addr_bad++;
        if (iss_c == 0 && iss_r < NL) first_addrs[iss_r] = {rd_addr0, rd_addr1, rd_addr2};
        if (iss_c == LW - 1) begin iss_c = 0; iss_r++; end else iss_c++;
      end
      if (pix_valid) begin
        if (row_o !== 9'(pv_r) || col_o !== 9'(pv_c)) seq_bad++;
        if (pv_r < NL) pix_per_row[pv_r]++;
        n_pix++;
        if (pv_c == LW - 1) begin pv_c = 0; pv_r++; end else pv_c++;
      end
      if (interrupt) n_int++;
      if (frame_done) begin n_done++; avail = 0; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bump_line();
    line_counter = (line_counter == 9'(NL - 1)) ? 9'd0 : line_counter + 9'd1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; line_counter = 9'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic preload_and_start(input int n);
    for (int i = 0; i < n; i++) begin tick(); bump_line(); end
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: always ready, 1: random stalls, 2: toggle. A stray start is pulsed mid-frame.
  task automatic run_frame(input int mode, input int limit, output bit done);
    done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = ~out_ready;
      endcase
      start = (i == 1000);
      tick();
      if (interrupt) bump_line();
      if (frame_done) done = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [55:0] ov;
    int rd_seen;
    rd_seen = 0;
    out_ready = 1'b1;
    do_reset();
    ov = {rd_en, rd_addr0, rd_addr1, rd_addr2, pix_valid, row_o, col_o, interrupt, busy, frame_done};
    n_cmp++;
    if (ov !== 56'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", ov); end
    for (int i = 0; i < 10; i++) begin tick(); if (rd_en) rd_seen++; end
    n_cmp++;
    if (rd_seen !== 0) begin n_bad++; $display("FAIL reset_no_rd: got %0d rd_en cycles want 0", rd_seen); end
  endtask

  task automatic test_first_window();
    do_reset();
    out_ready = 1'b1;
    preload_and_start(4);
    n_cmp++;
    if ({rd_en, busy} !== 2'b01) begin n_bad++; $display("FAIL first_wait: rd_en,busy=%b want 01", {rd_en, busy}); end
    tick();
    n_cmp++;
    if (rd_en !== 1'b1) begin n_bad++; $display("FAIL first_rd_latency: rd_en=%b want 1", rd_en); end
    n_cmp++;
    if ({rd_addr0, rd_addr1, rd_addr2} !== FIRST_ADDRS) begin
      n_bad++; $display("FAIL first_addrs: got %h/%h/%h want %h", rd_addr0, rd_addr1, rd_addr2, FIRST_ADDRS);
    end
    for (int i = 1; i < LW; i++) tick();
    n_cmp++;
    if ({rd_en, interrupt} !== 2'b10) begin n_bad++; $display("FAIL last_col_issue: rd_en,int=%b want 10", {rd_en, interrupt}); end
    tick();
    n_cmp++;
    if (interrupt !== EXP_INT1) begin n_bad++; $display("FAIL first_interrupt: got %b want %b", interrupt, EXP_INT1); end
  endtask

  task automatic test_full_frame();
    bit done;
    int s_pix, s_int, s_done, s_seq, s_other;
    do_reset();
    preload_and_start(4);
    s_pix = n_pix; s_int = n_int; s_done = n_done; s_seq = seq_bad;
    s_other = addr_bad + early_bad + ready_bad;
    run_frame(1, 3 * ROWS * LW, done);
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL frame_done_seen: got %b want 1", done); end
    tick(); tick();
    n_cmp++;
    if (n_pix - s_pix !== ROWS * LW) begin n_bad++; $display("FAIL pix_count: got %0d want %0d", n_pix - s_pix, ROWS * LW); end
    n_cmp++;
    if (n_int - s_int !== NL - 4) begin n_bad++; $display("FAIL interrupt_count: got %0d want %0d", n_int - s_int, NL - 4); end
    n_cmp++;
    if (n_done - s_done !== 1) begin n_bad++; $display("FAIL frame_done_count: got %0d want 1", n_done - s_done); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after_frame: got %b want 0", busy); end
    n_cmp++;
    if (seq_bad - s_seq !== 0) begin n_bad++; $display("FAIL pix_sequence: got %0d errors want 0", seq_bad - s_seq); end
    n_cmp++;
    if (addr_bad + early_bad + ready_bad - s_other !== 0) begin
      n_bad++; $display("FAIL read_issue: got %0d addr/early/ready errors want 0", addr_bad + early_bad + ready_bad - s_other);
    end
    n_cmp++;
    if (first_addrs[4] !== {11'h600, 11'h000, 11'h200}) begin
      n_bad++; $display("FAIL row4_addrs: got %h want 600/000/200", first_addrs[4]);
    end
`ifdef WINDOW_BORDER_EN
    n_cmp++;
    if (first_addrs[0] !== {11'h000, 11'h000, 11'h200}) begin
      n_bad++; $display("FAIL row0_addrs: got %h want 000/000/200", first_addrs[0]);
    end
    n_cmp++;
    if (first_addrs[NL-1] !== {11'h400, 11'h600, 11'h600}) begin
      n_bad++; $display("FAIL rowlast_addrs: got %h want 400/600/600", first_addrs[NL-1]);
    end
`endif
  endtask

  task automatic test_stall_toggle();
    int s_seq, s_rdy;
    do_reset();
    preload_and_start(4);
    s_seq = seq_bad; s_rdy = ready_bad;
    out_ready = 1'b0;
    for (int i = 0; i < 6 * LW && pix_per_row[1] < LW; i++) begin
      out_ready = ~out_ready;
      tick();
      if (interrupt) bump_line();
    end
    tick(); tick();
    n_cmp++;
    if (pix_per_row[1] !== LW) begin n_bad++; $display("FAIL toggle_row1_pix: got %0d want %0d", pix_per_row[1], LW); end
    n_cmp++;
    if (seq_bad - s_seq !== 0) begin n_bad++; $display("FAIL toggle_order: got %0d errors want 0", seq_bad - s_seq); end
    n_cmp++;
    if (ready_bad - s_rdy !== 0) begin n_bad++; $display("FAIL toggle_rd_no_ready: got %0d want 0", ready_bad - s_rdy); end
  endtask

  task automatic test_wrap_and_reset();
    bit done, hit;
    logic [55:0] ov;
    do_reset();
    preload_and_start(4);
    run_frame(0, 3 * ROWS * LW, done);
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL wrap_frame_done: got %b want 1", done); end
    n_cmp++;
    if (pix_per_row[LAST] !== LW) begin n_bad++; $display("FAIL wrap_last_row: got %0d pix want %0d", pix_per_row[LAST], LW); end
    do_reset();
    preload_and_start(4);
    out_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 8 * LW && !hit; i++) begin
      tick();
      if (interrupt) bump_line();
      if (pix_valid && row_o == 9'd3 && col_o == 9'd100) hit = 1'b1;
    end
    n_cmp++;
    if (hit !== 1'b1) begin n_bad++; $display("FAIL reach_row3_col100: got %b want 1", hit); end
    reset = 1'b1; line_counter = 9'd0;
    tick();
    ov = {rd_en, rd_addr0, rd_addr1, rd_addr2, pix_valid, row_o, col_o, interrupt, busy, frame_done};
    n_cmp++;
    if (ov !== 56'd0) begin n_bad++; $display("FAIL reset_mid_frame: got %h want 0", ov); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; line_counter = 9'd0; out_ready = 1'b1;
    for (int i = 0; i < NL; i++) begin pix_per_row[i] = 0; first_addrs[i] = '0; end
    test_reset();
    test_first_window();
    test_full_frame();
    test_stall_toggle();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
